// File: rtl/vga_draw_pkg.sv
// ---------------------------------------------------------------------------
// vga_draw_pkg
// Shared constants and types for the VGA pixel-write arbiter slice.
//   MODE_FIXED / MODE_RR   : arbitration policy selectors
//   SCREEN_W_DEF/H_DEF     : default visible area (used by the clip option)
//   X_W_DEF/Y_W_DEF/...    : default vga_adapter coordinate/colour widths
//   arb_state_e            : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package vga_draw_pkg;

    localparam int MODE_FIXED   = 0;
    localparam int MODE_RR      = 1;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    localparam int X_W_DEF      = 9;
    localparam int Y_W_DEF      = 8;
    localparam int COLOR_W_DEF  = 3;

    // owner index width covers up to 8 channels
    localparam int OWNER_W      = 3;
    localparam int CNT_W        = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vga_arb_pick.sv
// ---------------------------------------------------------------------------
// vga_arb_pick
// Combinational winner select for the pixel-write arbiter.
//   MODE_FIXED : lowest requesting index wins.
//   MODE_RR    : first requester at or after rr_ptr, wrapping modulo NUM_CH.
// Ports:
//   req         in  NUM_CH   per-channel request
//   rr_ptr      in  3        round-robin start index (ignored in fixed mode)
//   pick_onehot out NUM_CH   one-hot winner, all zero when nobody requests
//   pick_idx    out 3        winner index, 0 when nobody requests
// ---------------------------------------------------------------------------
module vga_arb_pick
    import vga_draw_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int MODE   = MODE_FIXED
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [OWNER_W-1:0] rr_ptr,
    output logic [NUM_CH-1:0]  pick_onehot,
    output logic [OWNER_W-1:0] pick_idx
);

    always_comb begin
        int   cand;
        logic found;
        cand        = 0;
        found       = 1'b0;
        pick_onehot = '0;
        pick_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (MODE == MODE_RR) begin
                cand = (int'(rr_ptr) + k) % NUM_CH;
            end else begin
                cand = k;
            end
            // compare against constant j so every select stays static
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && (j == cand) && req[j]) begin
                    found          = 1'b1;
                    pick_onehot[j] = 1'b1;
                    pick_idx       = OWNER_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter
// Registered, burst-locked N-channel pixel-write arbiter feeding vga_adapter.
// A client raises req, waits for its grant bit, then presents pixels with
// valid; each consumed pixel appears on plot/x/y/colour one cycle later.
// The burst ends when the owner drops req or after MAX_BURST pixels
// (0 = unlimited); one idle cycle always separates two grants.
//
// Optional build macro: VGA_DRAW_ARBITER_CLIP_EN
//   defined   : pixels outside SCREEN_W x SCREEN_H are consumed but not
//               plotted, and counted (saturating) in clip_count.
//   undefined : every consumed pixel is plotted, clip_count is 0.
//
// Ports:
//   clock, resetn        clock / asynchronous active-low reset
//   req, valid   [N]     per-channel request and pixel-present
//   x_in/y_in/color_in   packed per-channel pixel, channel i at [i*W +: W]
//   grant        [N]     one-hot owner
//   owner        [3]     owner index, 0 when idle
//   busy                 a grant is active
//   plot, x, y, colour   vga_adapter write port
//   clip_count   [16]    pixels dropped by clipping
// ---------------------------------------------------------------------------
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int MODE      = MODE_FIXED,
    parameter int MAX_BURST = 0,
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH-1:0]           valid,
    input  logic [NUM_CH*X_W-1:0]       x_in,
    input  logic [NUM_CH*Y_W-1:0]       y_in,
    input  logic [NUM_CH*COLOR_W-1:0]   color_in,
    output logic [NUM_CH-1:0]           grant,
    output logic [OWNER_W-1:0]          owner,
    output logic                        busy,
    output logic                        plot,
    output logic [X_W-1:0]              x,
    output logic [Y_W-1:0]              y,
    output logic [COLOR_W-1:0]          colour,
    output logic [CNT_W-1:0]            clip_count
);

    if (NUM_CH < 2 || NUM_CH > 8 || MODE < MODE_FIXED || MODE > MODE_RR ||
        MAX_BURST < 0 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_cfg
        $error("vga_draw_arbiter: unsupported parameter set");
    end

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [OWNER_W-1:0] ptr_after(input logic [OWNER_W-1:0] p);
        return (int'(p) + 1 >= NUM_CH) ? '0 : p + 1'b1;
    endfunction

    arb_state_e           state, state_nxt;
    logic [NUM_CH-1:0]    grant_nxt;
    logic [OWNER_W-1:0]   owner_nxt;
    logic                 busy_nxt;
    logic                 plot_nxt;
    logic [X_W-1:0]       x_nxt;
    logic [Y_W-1:0]       y_nxt;
    logic [COLOR_W-1:0]   colour_nxt;
    logic [CNT_W-1:0]     burst_cnt, burst_cnt_nxt, burst_inc;
    logic [OWNER_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_CH-1:0]    pick_onehot;
    logic [OWNER_W-1:0]   pick_idx;

    logic                 consume;
    logic                 own_req;
    logic                 burst_hit;
    logic                 clip_hit;
    logic [X_W-1:0]       own_x;
    logic [Y_W-1:0]       own_y;
    logic [COLOR_W-1:0]   own_c;

    vga_arb_pick #(
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_pick (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // grant is all-zero outside GRANT, so these are naturally gated by state
    assign consume   = |(grant & valid);
    assign own_req   = |(grant & req);
    assign burst_inc = sat_inc(burst_cnt);
    assign burst_hit = (MAX_BURST != 0) && consume && (burst_inc >= BURST_LIMIT);

    // one-hot OR mux of the owner's pixel
    always_comb begin
        own_x = '0;
        own_y = '0;
        own_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                own_x = own_x | x_in[i*X_W +: X_W];
                own_y = own_y | y_in[i*Y_W +: Y_W];
                own_c = own_c | color_in[i*COLOR_W +: COLOR_W];
            end
        end
    end

`ifdef VGA_DRAW_ARBITER_CLIP_EN
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    assign clip_hit = consume &&
                      (({1'b0, own_x} >= X_LIM) || ({1'b0, own_y} >= Y_LIM));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clip_count <= '0;
        end else if (clip_hit) begin
            clip_count <= sat_inc(clip_count);
        end
    end
`else
    assign clip_hit   = 1'b0;
    assign clip_count = '0;
`endif

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        owner_nxt     = owner;
        busy_nxt      = busy;
        plot_nxt      = 1'b0;
        x_nxt         = x;
        y_nxt         = y;
        colour_nxt    = colour;
        burst_cnt_nxt = burst_cnt;
        rr_ptr_nxt    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt     = ST_GRANT;
                    grant_nxt     = pick_onehot;
                    owner_nxt     = pick_idx;
                    busy_nxt      = 1'b1;
                    burst_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (consume) begin
                    burst_cnt_nxt = burst_inc;
                    plot_nxt      = !clip_hit;
                    if (!clip_hit) begin
                        x_nxt      = own_x;
                        y_nxt      = own_y;
                        colour_nxt = own_c;
                    end
                end
                // a pixel consumed on the exit cycle is still plotted above
                if (!own_req || burst_hit) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    owner_nxt = '0;
                    busy_nxt  = 1'b0;
                    if (MODE == MODE_RR) begin
                        rr_ptr_nxt = ptr_after(owner);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // stage p0 -> p1: arbitration decision and pixel register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            plot      <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            owner     <= owner_nxt;
            busy      <= busy_nxt;
            plot      <= plot_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            colour    <= colour_nxt;
            burst_cnt <= burst_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_draw_arbiter
// Two arbiter instances: a 2-channel fixed-priority one with unlimited bursts
// and a 4-channel round-robin one limited to 3-pixel bursts. Expected pixels
// are queued when a client presents them and matched against plot.
// ---------------------------------------------------------------------------
module tb_vga_draw_arbiter;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;
    localparam int NF = 2;
    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic [NF-1:0]    req_f, valid_f, grant_f;
    logic [NF*XW-1:0] x_in_f;
    logic [NF*YW-1:0] y_in_f;
    logic [NF*CW-1:0] color_in_f;
    logic [2:0]       owner_f;
    logic             busy_f, plot_f;
    logic [XW-1:0]    x_f;
    logic [YW-1:0]    y_f;
    logic [CW-1:0]    colour_f;
    logic [15:0]      clip_count_f;

    logic [NR-1:0]    req_r, valid_r, grant_r;
    logic [NR*XW-1:0] x_in_r;
    logic [NR*YW-1:0] y_in_r;
    logic [NR*CW-1:0] color_in_r;
    logic [2:0]       owner_r;
    logic             busy_r, plot_r;
    logic [XW-1:0]    x_r;
    logic [YW-1:0]    y_r;
    logic [CW-1:0]    colour_r;
    logic [15:0]      clip_count_r;

    vga_draw_arbiter #(
        .NUM_CH(NF), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
        .MODE(0), .MAX_BURST(0), .SCREEN_W(320), .SCREEN_H(240)
    ) u_dut_fix (
        .clock(clk), .resetn(resetn), .req(req_f), .valid(valid_f),
        .x_in(x_in_f), .y_in(y_in_f), .color_in(color_in_f),
        .grant(grant_f), .owner(owner_f), .busy(busy_f), .plot(plot_f),
        .x(x_f), .y(y_f), .colour(colour_f), .clip_count(clip_count_f)
    );

    vga_draw_arbiter #(
        .NUM_CH(NR), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
        .MODE(1), .MAX_BURST(3), .SCREEN_W(320), .SCREEN_H(240)
    ) u_dut_rr (
        .clock(clk), .resetn(resetn), .req(req_r), .valid(valid_r),
        .x_in(x_in_r), .y_in(y_in_r), .color_in(color_in_r),
        .grant(grant_r), .owner(owner_r), .busy(busy_r), .plot(plot_r),
        .x(x_r), .y(y_r), .colour(colour_r), .clip_count(clip_count_r)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_plot_f = 0;
    int n_plot_r = 0;
    logic [19:0] q_f[$];
    logic [19:0] q_r[$];
    logic [19:0] exp_f, exp_r;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] pix(input int px, input int py, input int pc);
        return {XW'(px), YW'(py), CW'(pc)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input int ch, input int px, input int py, input int pc);
        x_in_f[ch*XW +: XW]     = XW'(px);
        y_in_f[ch*YW +: YW]     = YW'(py);
        color_in_f[ch*CW +: CW] = CW'(pc);
    endtask

    task automatic drive_r(input int ch, input int px, input int py, input int pc);
        x_in_r[ch*XW +: XW]     = XW'(px);
        y_in_r[ch*YW +: YW]     = YW'(py);
        color_in_r[ch*CW +: CW] = CW'(pc);
    endtask

    // scoreboard: every plot must match the oldest queued pixel
    always @(negedge clk) begin
        if (resetn && plot_f) begin
            n_plot_f++;
            if (q_f.size() == 0) begin
                chk("fix_plot_unexpected", 32'(plot_f), 32'd0);
            end else begin
                exp_f = q_f.pop_front();
                chk("fix_pixel", 32'({x_f, y_f, colour_f}), 32'(exp_f));
            end
        end
        if (resetn && plot_r) begin
            n_plot_r++;
            if (q_r.size() == 0) begin
                chk("rr_plot_unexpected", 32'(plot_r), 32'd0);
            end else begin
                exp_r = q_r.pop_front();
                chk("rr_pixel", 32'({x_r, y_r, colour_r}), 32'(exp_r));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        int k;
        int base;
        logic [19:0] clip_pix [3];
        logic        clip_vis [3];

        resetn = 1'b0;
        req_f = '0; valid_f = '0; x_in_f = '0; y_in_f = '0; color_in_f = '0;
        req_r = '0; valid_r = '0; x_in_r = '0; y_in_r = '0; color_in_r = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk("rst_grant_f",  32'(grant_f), 32'd0);
        chk("rst_owner_f",  32'(owner_f), 32'd0);
        chk("rst_busy_f",   32'(busy_f), 32'd0);
        chk("rst_plot_f",   32'(plot_f), 32'd0);
        chk("rst_xyc_f",    32'({x_f, y_f, colour_f}), 32'd0);
        chk("rst_clip_f",   32'(clip_count_f), 32'd0);
        chk("rst_grant_r",  32'(grant_r), 32'd0);
        chk("rst_busy_r",   32'(busy_r), 32'd0);
        chk("rst_plot_r",   32'(plot_r), 32'd0);

        // fixed priority: both request, ch0 wins; ch1 holds a pixel meanwhile
        req_f = 2'b11;
        #3 resetn = 1'b1;
        tick();
        chk("fix_first_grant", 32'(grant_f), 32'h1);
        chk("fix_first_owner", 32'(owner_f), 32'd0);
        chk("fix_first_busy",  32'(busy_f), 32'd1);
        chk("fix_first_noplot", 32'(plot_f), 32'd0);
        drive_f(1, 100, 50, 5);
        valid_f[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_f(0, 10 + i, 20, i + 1);
            valid_f[0] = 1'b1;
            if (i == 3) req_f[0] = 1'b0;
            q_f.push_back(pix(10 + i, 20, i + 1));
            tick();
            chk("fix_plot_latency", 32'(plot_f), 32'd1);
        end
        valid_f[0] = 1'b0;
        chk("fix_bubble_grant", 32'(grant_f), 32'd0);
        chk("fix_bubble_busy",  32'(busy_f), 32'd0);
        q_f.push_back(pix(100, 50, 5));
        tick();
        chk("fix_second_grant", 32'(grant_f), 32'h2);
        chk("fix_second_owner", 32'(owner_f), 32'd1);
        chk("fix_no_plot_at_grant", 32'(plot_f), 32'd0);
        req_f[1] = 1'b0;
        tick();
        chk("fix_held_pixel_plot", 32'(plot_f), 32'd1);
        chk("fix_release_grant", 32'(grant_f), 32'd0);
        valid_f[1] = 1'b0;
        tick();
        chk("fix_idle_noplot", 32'(plot_f), 32'd0);
        chk("fix_plot_total", n_plot_f, 32'd5);

        // round-robin: one-pixel bursts, order 0,1,2,3,0
        req_r = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (grant_r == '0 && waited < 8) begin
                tick();
                waited++;
            end
            chk("rr_grant_order",  32'(owner_r), g % 4);
            chk("rr_grant_onehot", 32'(grant_r), 1 << (g % 4));
            chk("rr_bubble", waited, 32'd1);
            k = g % 4;
            drive_r(k, 20 + g, 10 + g, k + 1);
            valid_r[k] = 1'b1;
            req_r[k]   = 1'b0;
            q_r.push_back(pix(20 + g, 10 + g, k + 1));
            tick();
            chk("rr_plot", 32'(plot_r), 32'd1);
            chk("rr_release", 32'(grant_r), 32'd0);
            valid_r[k] = 1'b0;
            if (g < 4) req_r[k] = 1'b1;
            else       req_r = '0;
        end

        // burst limit of 3 with ch1 waiting
        req_r = 4'b0001;
        tick();
        chk("burst_grant_ch0", 32'(grant_r), 32'h1);
        req_r[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_r(0, 200 + i, 100, 6);
            valid_r[0] = 1'b1;
            q_r.push_back(pix(200 + i, 100, 6));
            tick();
            chk("burst_plot", 32'(plot_r), 32'd1);
            if (i < 2) chk("burst_busy_hold", 32'(busy_r), 32'd1);
        end
        chk("burst_limit_busy",  32'(busy_r), 32'd0);
        chk("burst_limit_grant", 32'(grant_r), 32'd0);
        drive_r(0, 203, 100, 6);
        tick();
        chk("burst_next_owner", 32'(grant_r), 32'h2);
        chk("burst_no_plot", 32'(plot_r), 32'd0);
        req_r = '0;
        valid_r = '0;
        tick();
        chk("burst_end_grant", 32'(grant_r), 32'd0);
        chk("rr_plot_total", n_plot_r, 32'd8);

        // clipping against 320x240
        clip_pix[0] = pix(319, 239, 1);
        clip_pix[1] = pix(320, 0, 2);
        clip_pix[2] = pix(0, 240, 3);
`ifdef VGA_DRAW_ARBITER_CLIP_EN
        clip_vis[0] = 1'b1; clip_vis[1] = 1'b0; clip_vis[2] = 1'b0;
`else
        clip_vis[0] = 1'b1; clip_vis[1] = 1'b1; clip_vis[2] = 1'b1;
`endif
        req_f = 2'b01;
        tick();
        chk("clip_grant", 32'(grant_f), 32'h1);
        base = n_plot_f;
        for (int i = 0; i < 3; i++) begin
            x_in_f[0 +: XW]     = clip_pix[i][19:11];
            y_in_f[0 +: YW]     = clip_pix[i][10:3];
            color_in_f[0 +: CW] = clip_pix[i][2:0];
            valid_f[0] = 1'b1;
            if (i == 2) req_f[0] = 1'b0;
            if (clip_vis[i]) q_f.push_back(clip_pix[i]);
            tick();
            chk("clip_plot_each", 32'(plot_f), 32'(clip_vis[i]));
        end
        valid_f = '0;
        tick();
`ifdef VGA_DRAW_ARBITER_CLIP_EN
        chk("clip_plots", n_plot_f - base, 32'd1);
        chk("clip_count", 32'(clip_count_f), 32'd2);
`else
        chk("clip_plots", n_plot_f - base, 32'd3);
        chk("clip_count", 32'(clip_count_f), 32'd0);
`endif

        // reset in the middle of a burst
        req_f = 2'b01;
        tick();
        chk("rmid_grant", 32'(grant_f), 32'h1);
        drive_f(0, 5, 6, 7);
        valid_f[0] = 1'b1;
        q_f.push_back(pix(5, 6, 7));
        tick();
        chk("rmid_plot_before", 32'(plot_f), 32'd1);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("rmid_plot_async",  32'(plot_f), 32'd0);
        chk("rmid_grant_async", 32'(grant_f), 32'd0);
        chk("rmid_busy_async",  32'(busy_f), 32'd0);
        chk("rmid_owner_async", 32'(owner_f), 32'd0);
        tick();
        tick();
        chk("rmid_plot_held", 32'(plot_f), 32'd0);
        chk("rmid_clip_count", 32'(clip_count_f), 32'd0);
        req_f = '0;
        valid_f = '0;
        #2 resetn = 1'b1;
        tick();
        chk("rmid_after_plot",  32'(plot_f), 32'd0);
        chk("rmid_after_busy",  32'(busy_f), 32'd0);
        chk("rmid_after_grant", 32'(grant_f), 32'd0);
        // round-robin pointer restarts at channel 0
        req_r = 4'b1111;
        tick();
        chk("rmid_rr_ptr", 32'(grant_r), 32'h1);
        req_r = '0;
        tick();
        chk("rmid_rr_release", 32'(grant_r), 32'd0);
        chk("rmid_after_plot2", 32'(plot_f), 32'd0);

        repeat (2) tick();
        chk("fix_queue_drained", q_f.size(), 32'd0);
        chk("rr_queue_drained",  q_r.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
